ex: RTL

Execute stage of the five-stage RV32 pipeline, between the ID/EX and EX/MEM pipeline registers.
- Computes RV32I ALU results, branch/jump redirects and load/store addresses combinationally.
- Adds an iterative RV32M multiply/divide unit that requests a pipeline stall until its result is ready.
- Its outputs also serve as the EX forwarding source for ID.

---
 rtl/ex_pkg.sv | 32 +++
 rtl/ex_if.sv | 30 +++
 rtl/ex_muldiv.sv | 92 +++++++++
 rtl/ex.sv | 67 ++++++
 4 files changed

// File: rtl/ex_pkg.sv
// ex_pkg: shared encodings, stall constants and op-class helpers for the execute stage
package ex_pkg;
  localparam logic [31:0] ZERO32 = '0;
  localparam int STALL_EX = 3;
  localparam logic STALL = 1'b1;
  localparam logic NO_STALL = 1'b0;
  localparam logic WRITE_DISABLE = 1'b0;
  localparam logic JUMP = 1'b1;
  typedef enum logic [2:0] {
    TYPE_NOP, TYPE_R, TYPE_I, TYPE_S, TYPE_B, TYPE_U, TYPE_J, TYPE_MULDIV
  } inst_type_e;
  typedef enum logic [5:0] {
    ID_NOP, ID_LUI, ID_AUIPC, ID_JAL, ID_JALR,
    ID_BEQ, ID_BNE, ID_BLT, ID_BGE, ID_BLTU, ID_BGEU,
    ID_LB, ID_LH, ID_LW, ID_LBU, ID_LHU, ID_SB, ID_SH, ID_SW,
    ID_ADD, ID_SUB, ID_SLL, ID_SLT, ID_SLTU, ID_XOR, ID_SRL, ID_SRA, ID_OR, ID_AND,
    ID_MUL, ID_MULH, ID_MULHSU, ID_MULHU, ID_DIV, ID_DIVU, ID_REM, ID_REMU
  } inst_idx_e;
  typedef enum logic [1:0] {MD_IDLE, MD_BUSY, MD_DONE} md_state_e;
  function automatic logic is_div(inst_idx_e op);
    return op inside {ID_DIV, ID_DIVU, ID_REM, ID_REMU};
  endfunction
  function automatic logic is_rem(inst_idx_e op);
    return op inside {ID_REM, ID_REMU};
  endfunction
  function automatic logic a_signed(inst_idx_e op);
    return op inside {ID_MUL, ID_MULH, ID_MULHSU, ID_DIV, ID_REM};
  endfunction
  function automatic logic b_signed(inst_idx_e op);
    return op inside {ID_MUL, ID_MULH, ID_DIV, ID_REM};
  endfunction
endpackage

// File: rtl/ex_if.sv
// ex_if: ID/EX-side inputs and EX/MEM-side outputs of the execute stage
interface ex_if;
  import ex_pkg::*;
  logic [5:0]  stall_in;
  logic [31:0] pc_in;
  logic        rdE_in;
  logic [4:0]  rdIdx_in;
  inst_idx_e   instIdx_in;
  inst_type_e  instType_in;
  logic [31:0] rs1Data_in;
  logic [31:0] rs2Data_in;
  logic [31:0] immData_in;
  logic        rdE_out;
  logic [4:0]  rdIdx_out;
  logic [31:0] rdData_out;
  inst_idx_e   instIdx_out;
  logic [31:0] memAddr_out;
  logic [31:0] memData_out;
  logic        pcJump_out;
  logic [31:0] pcTarget_out;
  logic        stallReq_out;
  modport master (
    output stall_in, pc_in, rdE_in, rdIdx_in, instIdx_in, instType_in, rs1Data_in, rs2Data_in, immData_in,
    input  rdE_out, rdIdx_out, rdData_out, instIdx_out, memAddr_out, memData_out, pcJump_out, pcTarget_out, stallReq_out
  );
  modport slave (
    input  stall_in, pc_in, rdE_in, rdIdx_in, instIdx_in, instType_in, rs1Data_in, rs2Data_in, immData_in,
    output rdE_out, rdIdx_out, rdData_out, instIdx_out, memAddr_out, memData_out, pcJump_out, pcTarget_out, stallReq_out
  );
endinterface

// File: rtl/ex_muldiv.sv
// ex_muldiv: iterative RV32M unit; shift-add multiply / restoring divide on sign magnitudes
module ex_muldiv
  import ex_pkg::*;
(
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        start,
  input  inst_idx_e   op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        hold_in,
  output logic [31:0] result,
  output logic        busy,
  output logic        done
);
  md_state_e state_q, state_d;
  inst_idx_e op_q, op_d;
  logic [4:0] cnt_q, cnt_d;
  logic [63:0] acc_q, acc_d;
  logic [31:0] m_q, m_d;
  logic neg_q, neg_d, negr_q, negr_d;
  logic sa, sb, zero_div, ovf;
  logic [31:0] ma, mb, quo, rem;
  logic [32:0] madd, dsub;
  logic [63:0] prod;
  assign sa = a_signed(op) & a[31];
  assign sb = b_signed(op) & b[31];
  assign ma = sa ? -a : a;
  assign mb = sb ? -b : b;
  assign zero_div = is_div(op) & (b == ZERO32);
  assign ovf = is_div(op) & b_signed(op) & (a == 32'h8000_0000) & (b == 32'hFFFF_FFFF);
  assign madd = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, m_q} : 33'd0);
  assign dsub = acc_q[63:31] - {1'b0, m_q};
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= MD_IDLE;
      op_q    <= ID_NOP;
      cnt_q   <= '0;
      acc_q   <= '0;
      m_q     <= '0;
      neg_q   <= 1'b0;
      negr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      m_q     <= m_d;
      neg_q   <= neg_d;
      negr_q  <= negr_d;
    end
  end
  // special divides skip BUSY with the final {remainder, quotient} preloaded unsigned-corrected
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    m_d     = m_q;
    neg_d   = neg_q;
    negr_d  = negr_q;
    case (state_q)
      MD_IDLE: if (start) begin
        op_d    = op;
        m_d     = mb;
        cnt_d   = '0;
        neg_d   = (zero_div | ovf) ? 1'b0 : sa ^ sb;
        negr_d  = (zero_div | ovf) ? 1'b0 : sa;
        acc_d   = zero_div ? {a, 32'hFFFF_FFFF} : ovf ? {32'h0, 32'h8000_0000} : {32'h0, ma};
        state_d = (zero_div | ovf) ? MD_DONE : MD_BUSY;
      end
      MD_BUSY: begin
        acc_d   = !is_div(op_q) ? {madd, acc_q[31:1]} :
                  !dsub[32] ? {dsub[31:0], acc_q[30:0], 1'b1} : {acc_q[62:0], 1'b0};
        cnt_d   = cnt_q + 5'd1;
        state_d = (cnt_q == 5'd31) ? MD_DONE : MD_BUSY;
      end
      MD_DONE: state_d = hold_in ? MD_DONE : MD_IDLE;
      default: state_d = MD_IDLE;
    endcase
  end
  always_comb begin
    busy   = state_q == MD_BUSY;
    done   = state_q == MD_DONE;
    prod   = neg_q ? -acc_q : acc_q;
    quo    = neg_q ? -acc_q[31:0] : acc_q[31:0];
    rem    = negr_q ? -acc_q[63:32] : acc_q[63:32];
    result = !done ? ZERO32 :
             is_div(op_q) ? (is_rem(op_q) ? rem : quo) :
             (op_q == ID_MUL) ? prod[31:0] : prod[63:32];
  end
endmodule

// File: rtl/ex.sv
// ex: RV32 execute stage; combinational RV32I ALU/branch/address logic plus a stalling RV32M unit
module ex
  import ex_pkg::*;
(
  input logic clk_in,
  input logic rst_in,
  ex_if.slave bus
);
  logic is_m, start, busy, done, taken, is_jalr, jump, eq, lt, ltu, unused_stall;
  logic [31:0] rs1, rs2, imm, opb, alu, md_result;
  inst_idx_e op;
  assign op = bus.instIdx_in;
  assign rs1 = bus.rs1Data_in;
  assign rs2 = bus.rs2Data_in;
  assign imm = bus.immData_in;
  assign opb = (bus.instType_in == TYPE_R) ? rs2 : imm;
  assign is_m = bus.instType_in == TYPE_MULDIV;
  assign start = is_m & ~busy & ~done;
  assign is_jalr = op == ID_JALR;
  assign eq = rs1 == rs2;
  assign lt = $signed(rs1) < $signed(rs2);
  assign ltu = rs1 < rs2;
  assign taken = op == ID_BEQ ? eq : op == ID_BNE ? !eq : op == ID_BLT ? lt :
                 op == ID_BGE ? !lt : op == ID_BLTU ? ltu : op == ID_BGEU ? !ltu : 1'b0;
  assign jump = !is_m & (taken | is_jalr | (op == ID_JAL));
  assign unused_stall = ^{bus.stall_in[5:4], bus.stall_in[2:0]};
  always_comb begin
    alu = ZERO32;
    case (op)
      ID_LUI:          alu = imm;
      ID_AUIPC:        alu = bus.pc_in + imm;
      ID_JAL, ID_JALR: alu = bus.pc_in + 32'd4;
      ID_ADD:          alu = rs1 + opb;
      ID_SUB:          alu = rs1 - opb;
      ID_SLL:          alu = rs1 << opb[4:0];
      ID_SLT:          alu = {31'b0, $signed(rs1) < $signed(opb)};
      ID_SLTU:         alu = {31'b0, rs1 < opb};
      ID_XOR:          alu = rs1 ^ opb;
      ID_SRL:          alu = rs1 >> opb[4:0];
      ID_SRA:          alu = $unsigned($signed(rs1) >>> opb[4:0]);
      ID_OR:           alu = rs1 | opb;
      ID_AND:          alu = rs1 & opb;
      default:         alu = ZERO32;
    endcase
  end
  ex_muldiv u_md (
    .clk_in  (clk_in),
    .rst_in  (rst_in),
    .start   (start),
    .op      (op),
    .a       (rs1),
    .b       (rs2),
    .hold_in (bus.stall_in[STALL_EX] == STALL),
    .result  (md_result),
    .busy    (busy),
    .done    (done)
  );
  assign bus.rdE_out      = rst_in ? WRITE_DISABLE : bus.rdE_in;
  assign bus.rdIdx_out    = rst_in ? 5'd0 : bus.rdIdx_in;
  assign bus.rdData_out   = rst_in ? ZERO32 : is_m ? md_result : alu;
  assign bus.instIdx_out  = rst_in ? ID_NOP : op;
  assign bus.memAddr_out  = rst_in ? ZERO32 : rs1 + imm;
  assign bus.memData_out  = rst_in ? ZERO32 : rs2;
  assign bus.pcJump_out   = rst_in ? !JUMP : jump;
  assign bus.pcTarget_out = rst_in ? ZERO32 : is_jalr ? (rs1 + imm) & 32'hFFFF_FFFE : bus.pc_in + imm;
  assign bus.stallReq_out = rst_in ? NO_STALL : start | busy;
endmodule
